nmcu_mem: RTL
=============

# nmcu_mem

Word-addressed scratchpad memory that serves the NMCU controller's shared memory port: descriptor, kernel and input reads, plus output writeback. Sits directly downstream of the controller's `mem_sel`/`mem_w`/`address_bus`/`data_bus`/`ready` interface. Emulates a fixed-latency SRAM with a one-cycle `ready` pulse per access. Provides a side-band debug read port for benches.

## Interface
- `ADDR_WIDTH`, 16: width of `address_bus` and `dbg_addr`.
- `DATABUS_WIDTH`, 32: word width.
- `DEPTH`, 1024: number of words; valid addresses are 0..DEPTH-1.
- `RD_LATENCY`, 2: cycles from request acceptance to `ready` for reads; must be ≥1.
- `WR_LATENCY`, 1: cycles from request acceptance to `ready` for writes; must be ≥1.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `mem_sel` in 1: request valid, held by the master until after `ready`.
- `mem_w` in 1: 1 = write, 0 = read; sampled with `mem_sel`.
- `address_bus` in ADDR_WIDTH: word address.
- `data_bus` inout DATABUS_WIDTH: write data in; read data out while `ready` is high on a read; Z otherwise.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: sticky out-of-range flag; cleared only by reset.
- `dbg_addr` in ADDR_WIDTH: debug read address.
- `dbg_rdata` out DATABUS_WIDTH: combinational `mem[dbg_addr]`; 0 if out of range.

## Operation
- FSM states: IDLE, BUSY, RESP, RELEASE.
- **IDLE:** when `mem_sel`=1 is sampled:
  - latch `address_bus`, `mem_w`, and `data_bus` (write only) into `req_addr`, `req_w`, `req_wdata`;
  - load the latency counter with RD_LATENCY-1 or WR_LATENCY-1;
  - go to BUSY if the counter value is >0, else RESP.
- **BUSY:** decrement the counter each cycle; at 0, go to RESP. Address and data changes on the bus during BUSY are ignored.
- **RESP** (exactly one cycle):
  - `ready`=1.
  - Write: `mem[req_addr] <= req_wdata` at the end of this cycle.
  - Read: drive `data_bus` with `mem[req_addr]`, registered into `rdata` on entry to RESP.
  - Then go to RELEASE.
- **RELEASE:** wait until `mem_sel`=0 is sampled, then go to IDLE. The master keeps `mem_sel` high for at least one cycle after `ready`; this state prevents a duplicate access.
- **Out of range** (`req_addr` ≥ DEPTH):
  - the access still completes with a normal `ready`;
  - a read returns 0;
  - a write is dropped;
  - `err` is set in the RESP cycle.
- `data_bus` drive enable = (state==RESP && !req_w). The block never drives the bus on writes or outside RESP.
- Memory contents are not cleared by reset; simulation initial value is 0.
- No simultaneous-request case exists, since there is a single master port. The debug port is read-only, never stalls, and reflects a RESP write from the next cycle.

## Timing
- Reset (`rst`=0 at a clock edge):
  - state becomes IDLE; `ready`=0; `err`=0; counter=0; `data_bus` released to Z;
  - an in-flight access is abandoned with no memory update, even if reset lands in RESP.
  - After reset, a `mem_sel` held high is treated as a new request.
- Request sampled in IDLE at edge T → `ready` high during cycle T+L, where L = RD_LATENCY or WR_LATENCY.
- Minimum spacing between accesses:
  - the master drops `mem_sel` at T+L+1;
  - RELEASE exits at T+L+2;
  - the next request can be sampled at T+L+2, so throughput is one access per L+2 cycles.
- `ready` is registered: high only in RESP, never on two consecutive cycles.
- `err` rises at the end of the RESP cycle of an offending access.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `mem_sel`=1 → `ready`=0, `err`=0, `data_bus`=Z; after release, exactly one access occurs.
- **Write then read (RD_LATENCY=2, WR_LATENCY=1):**
  - write 0xDEADBEEF to address 5 → `ready` 1 cycle after acceptance;
  - read address 5 → `ready` 2 cycles after acceptance with `data_bus`=0xDEADBEEF;
  - `dbg_rdata` at `dbg_addr`=5 = 0xDEADBEEF.
- **Held `mem_sel`:** master keeps `mem_sel`=1 for 4 cycles after `ready` → exactly one `ready` pulse; the next `ready` comes only after `mem_sel` has been low ≥1 cycle.
- **Controller-style burst:** preload descriptors at 0x10..0x12 (last has type bits 00) and run the ready/stall loop for 3 reads → data words returned in order, each `ready` spaced RD_LATENCY+2 cycles.
- **Out of range (DEPTH=1024):** write to address 1024 → `ready` pulses, `err`=1, `mem[0]` unchanged; a following read of 2000 returns 0; `err` stays 1 until reset.
- **Reset mid-access:** assert reset during BUSY of a write to address 7 → `mem[7]` unchanged, `ready` never pulses for that access.

Source files
------------

// File: rtl/nmcu_mem.sv
// nmcu_mem: word-addressed scratchpad memory. It serves the NMCU controller's
// shared memory port and behaves like a fixed-latency SRAM. Each access ends
// with a single-cycle ready pulse.
//
// Handshake: the master raises mem_sel, together with mem_w, address_bus and
// (for writes) data_bus. It holds mem_sel until after ready. The request is
// accepted on the first rising edge in IDLE that sees mem_sel=1. ready pulses
// for exactly one cycle, L cycles after acceptance (L = RD_LATENCY or
// WR_LATENCY). The block then waits in RELEASE until it samples mem_sel=0, so
// a held mem_sel never causes a second access.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-low reset
//   mem_sel     - request valid
//   mem_w       - 1 = write, 0 = read
//   address_bus - word address
//   data_bus    - write data in; read data out only during a read's RESP cycle
//   ready       - one-cycle completion pulse (registered)
//   err         - sticky out-of-range flag, cleared only by reset
//   dbg_addr    - side-band debug read address
//   dbg_rdata   - combinational mem[dbg_addr], 0 when out of range
//   fsm_state   - current FSM state (IDLE=0, BUSY=1, RESP=2, RELEASE=3)
module nmcu_mem #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATABUS_WIDTH = 32,
  parameter int DEPTH         = 1024,
  parameter int RD_LATENCY    = 2,
  parameter int WR_LATENCY    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_sel,
  input  logic                     mem_w,
  input  logic [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus,
  output logic                     ready,
  output logic                     err,
  input  logic [ADDR_WIDTH-1:0]    dbg_addr,
  output logic [DATABUS_WIDTH-1:0] dbg_rdata,
  output logic [1:0]               fsm_state
);

  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Not reset; contents survive reset.
  logic [DATABUS_WIDTH-1:0] mem [DEPTH];

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic                     req_w;
  logic [DATABUS_WIDTH-1:0] req_wdata;
  logic [DATABUS_WIDTH-1:0] rdata;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < (ADDR_WIDTH + 1)'(DEPTH);
  endfunction

  // Read path into rdata. When the latency is 1, RESP is entered straight
  // from IDLE, and req_addr is being loaded on that same edge. In that case
  // the live address is used instead.
  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic [DATABUS_WIDTH-1:0] rd_word;
  logic                     req_in_range;
  logic [CNT_W-1:0]         lat_load;

  always_comb begin
    rd_addr = (state == IDLE) ? address_bus : req_addr;
    rd_word = '0;
    if (addr_ok(rd_addr)) rd_word = mem[rd_addr[IDX_W-1:0]];
  end

  assign req_in_range = addr_ok(req_addr);
  assign lat_load     = mem_w ? WR_LOAD : RD_LOAD;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      req_addr  <= '0;
      req_w     <= 1'b0;
      req_wdata <= '0;
      rdata     <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_sel) begin
            req_addr <= address_bus;
            req_w    <= mem_w;
            if (mem_w) req_wdata <= data_bus;
            cnt <= lat_load;
            if (lat_load != '0) begin
              state <= BUSY;
            end else begin
              state <= RESP;
              ready <= 1'b1;
              rdata <= rd_word;
            end
          end
        end
        BUSY: begin
          // The bus is ignored here; only the latched request matters.
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            state <= RESP;
            ready <= 1'b1;
            rdata <= rd_word;
          end
        end
        RESP: begin
          state <= RELEASE;
          if (!req_in_range) err <= 1'b1;
        end
        RELEASE: begin
          if (!mem_sel) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The write commits at the edge that ends RESP. A reset landing on that
  // edge suppresses it, so an abandoned access never updates memory.
  always_ff @(posedge clk) begin
    if (rst && state == RESP && req_w && req_in_range)
      mem[req_addr[IDX_W-1:0]] <= req_wdata;
  end

  assign data_bus  = (state == RESP && !req_w) ? rdata : {DATABUS_WIDTH{1'bz}};
  assign dbg_rdata = addr_ok(dbg_addr) ? mem[dbg_addr[IDX_W-1:0]] : '0;
  assign fsm_state = state;

endmodule
